// File: rtl/tern_pkg.sv
// Shared definitions for the ternary MAC array.
//
// Provides:
//   - the 2-bit ternary weight encoding (00 = 0, 01 = +1, 1x = -1)
//   - decode_ternary : 2-bit code -> {zero, neg} flags
//   - sat_shift_relu : arithmetic right shift, optional ReLU clamp and
//                      saturation to a signed out_w-bit range. The value is
//                      carried at CALC_W bits so that one function serves
//                      any ACC_W / OUT_W the array is built with.
package tern_pkg;

    localparam logic [1:0] TW_ZERO     = 2'b00;
    localparam logic [1:0] TW_POS      = 2'b01;
    localparam int         TW_SIGN_BIT = 1;
    localparam int         CALC_W      = 64;

    typedef struct packed {
        logic zero;
        logic neg;
    } tern_dec_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    // 00 contributes nothing; both 10 and 11 mean -1, so bit 1 alone is the sign.
    function automatic tern_dec_t decode_ternary(input logic [1:0] w);
        tern_dec_t d;
        d.zero = (w == TW_ZERO);
        d.neg  = w[TW_SIGN_BIT];
        return d;
    endfunction

    // Caller sign-extends the accumulator into CALC_W bits and keeps the
    // low out_w bits of the result.
    function automatic logic signed [CALC_W-1:0] sat_shift_relu(
        input logic signed [CALC_W-1:0] value,
        input int unsigned              shift,
        input logic                     relu,
        input int unsigned              out_w
    );
        logic signed [CALC_W-1:0] v;
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        v  = value >>> shift;
        if (relu && (v < 0)) begin
            v = '0;
        end
        hi = $signed((64'd1 << (out_w - 1)) - 64'd1);
        lo = ~hi;
        if (v > hi) begin
            v = hi;
        end else if (v < lo) begin
            v = lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/ternary_mac_cell.sv
// One ternary multiply-accumulate cell.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (acc -> 0)
//   valid       : a beat is present this cycle
//   zero, sign  : decoded weight (zero => no contribution, sign => subtract)
//   act         : signed activation, sign-extended to ACC_W
//   clear       : snapshot taken this cycle; accumulator restarts from 0
//   acc_next    : value the accumulator would take without clear
//   acc         : registered accumulator (wraps modulo 2^ACC_W)
module ternary_mac_cell #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 17
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid,
    input  logic                    zero,
    input  logic                    sign,
    input  logic signed [IN_W-1:0]  act,
    input  logic                    clear,
    output logic signed [ACC_W-1:0] acc_next,
    output logic signed [ACC_W-1:0] acc
);

    logic signed [ACC_W-1:0] act_ext;

    assign act_ext = {{(ACC_W-IN_W){act[IN_W-1]}}, act};

    always_comb begin
        acc_next = acc;
        if (valid && !zero) begin
            acc_next = sign ? (acc - act_ext) : (acc + act_ext);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/ternary_mac_array.sv
// ROWS x COLS array of ternary-weight MAC cells with a double-buffered
// readout queue.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid         : beat present (never back-pressured)
//   in_weights       : row r ternary code at [2r+1:2r]
//   in_acts          : column c signed activation at [c*IN_W +: IN_W]
//   start_readout    : pulse; snapshot + clear accumulators when not busy
//   shift, relu_en   : output post-processing, latched at snapshot
//   out_data         : post-processed queue element (row-major order)
//   out_valid/ready  : output handshake
//   out_last         : final element of the stream
//   busy             : queue is draining
//   readout_dropped  : sticky, a readout request arrived while busy
module ternary_mac_array
    import tern_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 2,
    parameter int IN_W  = 8,
    parameter int ACC_W = 17,
    parameter int OUT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [2*ROWS-1:0]          in_weights,
    input  logic [COLS*IN_W-1:0]       in_acts,
    input  logic                       start_readout,
    input  logic [$clog2(ACC_W)-1:0]   shift,
    input  logic                       relu_en,
    output logic signed [OUT_W-1:0]    out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last,
    output logic                       busy,
    output logic                       readout_dropped
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(ACC_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    drain_state_t            state;
    drain_state_t            state_nxt;
    logic [IDX_W-1:0]        index;
    logic [SH_W-1:0]         shift_lat;
    logic                    relu_lat;
    logic signed [ACC_W-1:0] queue    [N];
    logic signed [ACC_W-1:0] acc_next [N];
    logic signed [ACC_W-1:0] acc_q    [N];

    logic handshake;
    logic final_hs;
    logic snap_accept;
    logic snap_drop;

    logic signed [CALC_W-1:0] q_ext;
    logic signed [CALC_W-1:0] post;

    // ---------------- MAC cell grid ----------------
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        tern_dec_t dec;
        assign dec = decode_ternary(in_weights[2*r +: 2]);
        for (genvar c = 0; c < COLS; c++) begin : g_col
            ternary_mac_cell #(
                .IN_W  (IN_W),
                .ACC_W (ACC_W)
            ) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .valid    (in_valid),
                .zero     (dec.zero),
                .sign     (dec.neg),
                .act      (in_acts[c*IN_W +: IN_W]),
                .clear    (snap_accept),
                .acc_next (acc_next[r*COLS+c]),
                .acc      (acc_q[r*COLS+c])
            );
        end
    end

    // ---------------- handshake / FSM ----------------
    assign handshake = out_valid && out_ready;
    assign final_hs  = handshake && (index == LAST_IDX);
    // The final handshake frees the queue in the same cycle, so a request
    // arriving then is taken back-to-back instead of being dropped.
    assign snap_accept = start_readout && ((state == ST_IDLE) || final_hs);
    assign snap_drop   = start_readout && (state == ST_DRAIN) && !final_hs;

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (snap_accept) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (final_hs && !snap_accept) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            index           <= '0;
            shift_lat       <= '0;
            relu_lat        <= 1'b0;
            readout_dropped <= 1'b0;
        end else begin
            state <= state_nxt;
            if (snap_accept) begin
                index     <= '0;
                shift_lat <= shift;
                relu_lat  <= relu_en;
            end else if (handshake) begin
                index <= index + 1'b1;
            end
            if (snap_drop) begin
                readout_dropped <= 1'b1;
            end
        end
    end

    // ---------------- snapshot queue ----------------
    // acc_next already folds in a same-cycle beat; with no beat it equals acc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                queue[i] <= '0;
            end
        end else if (snap_accept) begin
            for (int i = 0; i < N; i++) begin
                queue[i] <= in_valid ? acc_next[i] : acc_q[i];
            end
        end
    end

    // ---------------- output post-processing ----------------
    always_comb begin
        q_ext    = {{(CALC_W-ACC_W){queue[index][ACC_W-1]}}, queue[index]};
        post     = sat_shift_relu(q_ext, 32'(shift_lat), relu_lat, OUT_W);
        out_data = OUT_W'(post);
        out_last = out_valid && (index == LAST_IDX);
    end

endmodule

// File: tb/tb_ternary_mac_array.sv
module tb_ternary_mac_array;

    localparam int ROWS  = 4;
    localparam int COLS  = 2;
    localparam int IN_W  = 8;
    localparam int ACC_W = 17;
    localparam int OUT_W = 8;
    localparam int SH_W  = $clog2(ACC_W);

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [2*ROWS-1:0]        in_weights;
    logic [COLS*IN_W-1:0]     in_acts;
    logic                     start_readout;
    logic [SH_W-1:0]          shift;
    logic                     relu_en;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;
    logic                     readout_dropped;

    typedef struct {
        logic signed [OUT_W-1:0] data;
        logic                    last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    int   hs_cnt = 0;

    ternary_mac_array #(
        .ROWS (ROWS), .COLS (COLS), .IN_W (IN_W), .ACC_W (ACC_W), .OUT_W (OUT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_weights      (in_weights),
        .in_acts         (in_acts),
        .start_readout   (start_readout),
        .shift           (shift),
        .relu_en         (relu_en),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_last        (out_last),
        .busy            (busy),
        .readout_dropped (readout_dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, pops one expectation per handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got %0d, expected no element", out_data);
            end else begin
                e = exp_q.pop_front();
                check("stream_data", out_data, e.data);
                check("stream_last", out_last, e.last);
            end
        end
    end

    task automatic push_row(input int a, input int b, input bit final_row);
        exp_t e;
        e.data = OUT_W'(a); e.last = 1'b0;      exp_q.push_back(e);
        e.data = OUT_W'(b); e.last = final_row; exp_q.push_back(e);
    endtask

    task automatic push_rows_same(input int a, input int b);
        for (int r = 0; r < ROWS; r++) push_row(a, b, r == ROWS - 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2*ROWS-1:0] w, input int a0, input int a1,
                        input bit vld, input bit st);
        in_valid      = vld;
        in_weights    = w;
        in_acts       = {8'(a1), 8'(a0)};
        start_readout = st;
        step();
        in_valid      = 1'b0;
        start_readout = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            step();
            k++;
        end
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_all_popped"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_weights = '0; in_acts = '0;
        start_readout = 1'b0; shift = '0; relu_en = 1'b0; out_ready = 1'b1;
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_last", out_last, 0);
        check("rst_dropped", readout_dropped, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Accumulate 3 beats of (5,-3) with all weights +1, read on beat 3.
        push_rows_same(15, -9);
        beat(8'b01010101, 5, -3, 1, 0);
        beat(8'b01010101, 5, -3, 1, 0);
        beat(8'b01010101, 5, -3, 1, 1);
        check("t1_busy_after_snap", busy, 1);
        check("t1_valid_after_snap", out_valid, 1);
        wait_drain("t1");

        // Weight decode {00,01,10,11} with act 100 twice; saturation at +-128.
        push_row(0, 0, 0);
        push_row(127, 127, 0);
        push_row(-128, -128, 0);
        push_row(-128, -128, 1);
        beat(8'b11100100, 100, 100, 1, 0);
        beat(8'b11100100, 100, 100, 1, 1);
        wait_drain("t2");

        // acc = -40 / 300, shift 2 + ReLU -> 0 / 75; settings change mid-drain.
        push_rows_same(0, 75);
        shift = 2; relu_en = 1'b1;
        beat(8'b01010101, -40, 100, 1, 0);
        beat(8'b01010101, 0, 100, 1, 0);
        beat(8'b01010101, 0, 100, 1, 1);
        shift = 0; relu_en = 1'b0;
        wait_drain("t3");

        // Backpressure: weights r0=+1 r1=-1 r2=0 r3=+1, acts (7,-2).
        push_row(7, -2, 0);
        push_row(-7, 2, 0);
        push_row(0, 0, 0);
        push_row(7, -2, 1);
        hs_cnt = 0;
        beat(8'b01001001, 7, -2, 1, 1);
        step(); step(); step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_data", out_data, 2);
            check("t4_stall_valid", out_valid, 1);
            check("t4_stall_last", out_last, 0);
            step();
        end
        out_ready = 1'b1;
        wait_drain("t4");
        check("t4_handshake_count", hs_cnt, ROWS * COLS);

        // Double buffering: beats during drain, dropped request, back-to-back snapshot.
        check("t5_dropped_before", readout_dropped, 0);
        push_rows_same(1, 1);
        push_rows_same(16, 24);
        beat(8'b01010101, 1, 1, 1, 1);
        for (int i = 0; i < 8; i++) begin
            beat(8'b01010101, 2, 3, 1, (i == 2) || (i == 7));
        end
        check("t5_dropped_set", readout_dropped, 1);
        check("t5_busy_back_to_back", busy, 1);
        wait_drain("t5");

        // Async reset mid-drain, then a readout with no beats returns zeros.
        out_ready = 1'b0;
        beat(8'b01010101, 9, 9, 1, 0);
        beat(8'b01010101, 4, 4, 1, 1);
        beat(8'b01010101, 6, 6, 1, 0);
        check("t6_busy_before_rst", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_out_valid", out_valid, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_out_last", out_last, 0);
        check("t6_rst_out_data", out_data, 0);
        check("t6_rst_dropped", readout_dropped, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        push_rows_same(0, 0);
        beat(8'b01010101, 0, 0, 0, 1);
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ternary_mac_array.md
Name: ternary_mac_array

Overview:
- Parametrised ROWS x COLS array of 1.58-bit (ternary weight x signed activation) multiply-accumulate cells, for the tinytapeout matrix-multiply datapath.
- Each accepted beat brings one ternary weight per row and one signed activation per column.
- On a readout request, the accumulators are snapshotted into an output queue and cleared in the same cycle. The snapshot is then streamed out one element per handshake, with shift, ReLU and saturation applied.
- Accumulation continues while the queue drains (double-buffered).

Parameters:
- ROWS, 4, number of weight rows (≥1)
- COLS, 2, number of activation columns (≥1)
- IN_W, 8, signed activation width
- ACC_W, 17, signed accumulator width (≥ IN_W+1)
- OUT_W, 8, signed output element width (≤ ACC_W)

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  weight/activation beat present; always accepted, no input backpressure
- in_weights  in  2*ROWS  row r at bits [2r+1:2r]; 00 = 0, 01 = +1, 10 or 11 = -1
- in_acts  in  COLS*IN_W  column c at [c*IN_W +: IN_W], two's complement
- start_readout  in  1  single-cycle pulse: snapshot and clear accumulators
- shift  in  $clog2(ACC_W)  arithmetic right shift applied at output, sampled at snapshot
- relu_en  in  1  clamp negative outputs to 0, sampled at snapshot
- out_data  out  OUT_W  current queue element after post-processing
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_last  out  1  high with the final element (index ROWS*COLS-1)
- busy  out  1  high while the queue is draining
- readout_dropped  out  1  sticky; set when start_readout arrives while busy, cleared by reset only

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - all accumulators = 0, queue = 0, index = 0, FSM = IDLE
  - out_valid = 0, out_last = 0, busy = 0, readout_dropped = 0, out_data = 0
- Accumulate, every cycle with in_valid = 1, for each r and c:
  - acc[r][c] += w[r] * act[c], with w in {-1, 0, +1}
  - sign-extend act to ACC_W; wrap modulo 2^ACC_W (no saturation)
  - in_valid = 0: accumulators hold
- Snapshot, on start_readout while FSM = IDLE:
  - queue[r*COLS+c] <= acc_next[r][c] (the same-cycle beat is included)
  - acc <= 0, so the same-cycle beat does not also count toward the next batch
  - latch shift and relu_en; index <= 0; FSM -> DRAIN
- Snapshot ignored while in DRAIN: accumulators keep accumulating and are not cleared; readout_dropped <= 1.
- FSM:
  - IDLE: out_valid = 0, busy = 0
  - DRAIN: busy = 1, out_valid = 1 from the cycle after the snapshot (1-cycle latency)
  - on each handshake, index++
  - handshake at index ROWS*COLS-1 -> IDLE; out_valid drops next cycle
  - a start_readout in that same cycle is treated as IDLE-state (accepted, back-to-back)
- Output element (combinational from queue[index]):
  - v = queue[index] >>> shift_latched (arithmetic)
  - if relu_latched and v < 0, then v = 0
  - saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]
  - out_last = (index == ROWS*COLS-1) && out_valid
- Backpressure: while out_valid && !out_ready, out_data, out_last and index are stable.
- Reset mid-DRAIN: immediate return to the reset state; the partial stream is abandoned.

Decomposition:
- Shared package tern_pkg:
  - ternary encoding constants (TW_ZERO = 2'b00, TW_POS = 2'b01, sign bit = bit 1)
  - function decode_ternary
  - function sat_shift_relu(value, shift, relu, OUT_W)
- Sub-module ternary_mac_cell: one accumulator, inputs valid/zero/sign/act/clear, output acc_next and acc; instantiated ROWS*COLS times via generate.
- FSM, queue and output post-processing stay in the top block.

Test Plan:
- Accumulate and read out:
  - ROWS = 4, COLS = 2; 3 beats, weights all 01, acts (5, -3) each beat; start_readout on beat 3
  - expect 8 elements, row-major: 15, -9 repeated; out_last on the 8th; busy 1 -> 0
- Weight decode and saturation:
  - weights {00, 01, 10, 11}, act 100 for 2 beats, shift 0
  - expect rows: 0, 127 (200 saturated), -128 (-200 saturated), -128
- Shift and ReLU:
  - acc = -40 and 300; shift = 2, relu_en = 1
  - expect 0 and 75
- Backpressure:
  - hold out_ready = 0 for 5 cycles mid-stream
  - expect out_data and index stable; no element lost or duplicated; total count = ROWS*COLS
- Double-buffering:
  - beats continue during DRAIN; start_readout while busy sets readout_dropped = 1
  - start_readout coincident with the final handshake yields a second stream containing every beat since the first snapshot
- Async reset mid-DRAIN:
  - drop rst_n between clock edges
  - expect out_valid = 0 and busy = 0 immediately
  - after release, a readout returns all zeros
